ctrl_pipe_reg: RTL

CTRL_PIPE_REG -- requirements
Module: ctrl_pipe_reg

---
 rtl/ctrl_pipe_reg.sv | 79 +++++++
 1 files changed

// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg -- DEPTH-stage control-word pipeline with stall, flush and an
// occupancy count.
//
// Each stage holds a valid bit and a WIDTH-bit control word. Stage 0 captures
// the incoming word and the last stage drives the outputs straight from flops.
// The word of an invalid stage is always zero, so a bubble never asserts a
// control bit downstream. Flush takes priority over stall.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset, clears every stage and the count
//   stall     - holds every stage; the input word is dropped
//   flush     - clears every stage (wins over stall)
//   valid_i   - data_i carries a live control word
//   data_i    - control word entering stage 0 (ignored when valid_i=0)
//   valid_o   - valid bit of the last stage
//   data_o    - control word of the last stage
//   occupancy - registered number of valid stages (0..DEPTH)
module ctrl_pipe_reg #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    occupancy
);

  localparam int LAST = DEPTH - 1;

  // Stage k lives in bit k of vld and slice [k*WIDTH +: WIDTH] of wordVec,
  // so advancing the pipe is a left shift with the new stage 0 OR-ed in.
  // This keeps DEPTH=1 free of empty or negative-width selects.
  logic [DEPTH-1:0]       vld;
  logic [DEPTH*WIDTH-1:0] wordVec;

  logic [WIDTH-1:0] inWord;
  logic             lastValid;
  logic [CW-1:0]    occNext;

  assign inWord    = valid_i ? data_i : '0;
  assign lastValid = vld[LAST];

  // On an advancing edge one word may enter and the last one leaves.
  always_comb begin
    occNext = occupancy;
    if (valid_i && !lastValid) begin
      occNext = occupancy + CW'(1);
    end else if (!valid_i && lastValid) begin
      occNext = occupancy - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      wordVec   <= '0;
      occupancy <= '0;
    end else if (flush) begin
      vld       <= '0;
      wordVec   <= '0;
      occupancy <= '0;
    end else if (!stall) begin
      vld       <= (vld << 1) | DEPTH'(valid_i);
      wordVec   <= (wordVec << WIDTH) | (DEPTH*WIDTH)'(inWord);
      occupancy <= occNext;
    end
  end

  assign valid_o = lastValid;
  assign data_o  = wordVec[LAST*WIDTH +: WIDTH];

endmodule
